// File: rtl/hdmi_i2c_responder.sv
// I2C target standing in for the HDMI transmitter's configuration port: 8-bit register
// file behind an auto-incrementing pointer, with one read-only chip-ID register.
module hdmi_i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter logic [7:0] ID_ADDR  = 8'hF5,
    parameter logic [7:0] ID_VALUE = 8'h75
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK      = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_ack_on;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_wr_en;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_mem [256];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_rx_byte, w_ptr_inc, w_rd_cur, w_rd_next;

    // Synchronisers reset to the idle-bus level so reset alone creates no bus events.
    always_ff @(posedge clock50) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_rx_byte  = {r_shift[6:0], r_sda_s2};
    assign w_ptr_inc  = r_ptr + 8'd1;
    assign w_rd_cur   = (r_ptr == ID_ADDR) ? ID_VALUE : r_mem[r_ptr];
    assign w_rd_next  = (w_ptr_inc == ID_ADDR) ? ID_VALUE : r_mem[w_ptr_inc];

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= 8'd0;
            r_rw      <= 1'b0;
            r_ack_on  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_ack_on <= 1'b0;
            end else if (w_start) begin
                r_state  <= S_ADDR;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b1;
                r_ack_on <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte;
                            r_cnt   <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7) begin
                                r_cnt <= 4'd0;
                                if (r_state == S_ADDR) begin
                                    r_rw    <= w_rx_byte[0];
                                    r_state <= (w_rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                                end else if (r_state == S_PTR) begin
                                    r_ptr   <= w_rx_byte;
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    if (r_ptr != ID_ADDR) begin
                                        r_wr_en   <= 1'b1;
                                        r_wr_addr <= r_ptr;
                                        r_wr_data <= w_rx_byte;
                                    end
                                    r_ptr   <= w_ptr_inc;
                                    r_state <= S_WDATA_ACK;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        // First fall pulls SDA for the ACK slot, second fall ends it.
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_ack_on <= 1'b0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_sda_oe <= ~w_rd_cur[7];
                                    r_shift  <= {w_rd_cur[6:0], 1'b0};
                                    r_cnt    <= 4'd1;
                                    r_state  <= S_RDATA;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_cnt    <= 4'd0;
                                    r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_cnt    <= 4'd0;
                                r_state  <= S_RACK;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_cnt    <= r_cnt + 4'd1;
                            end
                        end
                    end
                    S_RACK: begin
                        if (w_scl_rise) begin
                            if (!r_sda_s2) begin
                                r_ptr   <= w_ptr_inc;
                                r_shift <= w_rd_next;
                                r_cnt   <= 4'd0;
                                r_state <= S_RDATA;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The register array lags wr_en by one clock.
    always_ff @(posedge clock50) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) r_mem[i] <= 8'd0;
        end else if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_hdmi_i2c_responder.sv
// Bus-level bench: an I2C initiator drives transactions, a transaction-level model
// predicts ACKs, read bytes and register writes, and monitors score what the target produces.
module tb_hdmi_i2c_responder;

    localparam logic [7:0] ID_ADDR  = 8'hF5;
    localparam logic [7:0] ID_VALUE = 8'h75;
    localparam int HALF = 10;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b1;
    logic       scl_m   = 1'b1;
    logic       sda_m   = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data;

    assign sda_line = sda_m & ~sda_oe;

    always #10 clock50 = ~clock50;

    hdmi_i2c_responder dut (
        .clock50 (clock50),
        .reset   (reset),
        .scl_in  (scl_m),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_wr_q[$];
    int exp_rx_q[$];
    int obs_rx_q[$];
    logic [7:0] m_mem[256];
    logic [7:0] m_ptr;
    logic [7:0] wbuf[$];
    logic quiet = 1'b0;
    int   oe_count = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge clock50);
    endtask

    function automatic logic [7:0] m_rd(input logic [7:0] a);
        return (a == ID_ADDR) ? ID_VALUE : m_mem[a];
    endfunction

    // Scoreboard monitors: register-write port and bus responses seen by the initiator.
    initial begin
        forever begin
            @(negedge clock50);
            if (quiet && sda_oe) oe_count++;
            if (wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, required no write", wr_addr, wr_data);
                end else begin
                    check("wr_txn", {wr_addr, wr_data}, exp_wr_q.pop_front());
                end
            end
            while (obs_rx_q.size() > 0) begin
                int obs;
                obs = obs_rx_q.pop_front();
                if (exp_rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h, required nothing", obs);
                end else begin
                    check("rx_ack_or_byte", obs, exp_rx_q.pop_front());
                end
            end
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1;
        clk(5);
        scl_m = 1'b1;
        clk(HALF);
        sda_m = 1'b0;
        clk(HALF);
        @(negedge clock50);
        check("busy_after_start", busy, 1);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clk(5);
        sda_m = 1'b0;
        clk(5);
        scl_m = 1'b1;
        clk(HALF);
        sda_m = 1'b1;
        clk(HALF);
        @(negedge clock50);
        check("busy_after_stop", busy, 0);
    endtask

    task automatic write_bit(input logic b);
        clk(5);
        sda_m = b;
        clk(5);
        scl_m = 1'b1;
        clk(HALF);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        clk(5);
        sda_m = 1'b1;
        clk(5);
        scl_m = 1'b1;
        clk(5);
        @(negedge clock50);
        b = sda_line;
        clk(5);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(a);
        obs_rx_q.push_back(32'h100 | int'(a));
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] v;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        obs_rx_q.push_back(int'(v));
        write_bit(nack);
    endtask

    task automatic exp_ack(input logic a);
        exp_rx_q.push_back(32'h100 | int'(a));
    endtask

    // Write transaction: 0x72, pointer, then the bytes queued in wbuf.
    task automatic txn_write(input logic [7:0] ptr, input logic do_stop);
        $display("txn write ptr=%02h len=%0d", ptr, wbuf.size());
        exp_ack(1'b0);
        exp_ack(1'b0);
        m_ptr = ptr;
        foreach (wbuf[i]) begin
            exp_ack(1'b0);
            if (m_ptr != ID_ADDR) begin
                exp_wr_q.push_back({16'd0, m_ptr, wbuf[i]});
                m_mem[m_ptr] = wbuf[i];
            end
            m_ptr = m_ptr + 8'd1;
        end
        i2c_start();
        write_byte(8'h72);
        write_byte(ptr);
        foreach (wbuf[i]) write_byte(wbuf[i]);
        if (do_stop) i2c_stop();
    endtask

    // Read n bytes, optionally setting the pointer first with a repeated START.
    task automatic txn_read(input int n, input logic set_ptr, input logic [7:0] ptr);
        $display("txn read set_ptr=%0d ptr=%02h len=%0d", set_ptr, set_ptr ? ptr : m_ptr, n);
        if (set_ptr) begin
            exp_ack(1'b0);
            exp_ack(1'b0);
            m_ptr = ptr;
        end
        exp_ack(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_rx_q.push_back(int'(m_rd(m_ptr)));
            if (i < n - 1) m_ptr = m_ptr + 8'd1;
        end
        if (set_ptr) begin
            i2c_start();
            write_byte(8'h72);
            write_byte(ptr);
        end
        i2c_start();
        write_byte(8'h73);
        for (int i = 0; i < n; i++) read_byte(i == n - 1);
        i2c_stop();
    endtask

    task automatic txn_wrong(input logic [6:0] addr7, input int n);
        $display("txn wrong-address addr=%02h bytes=%0d", addr7, n);
        exp_ack(1'b1);
        for (int i = 0; i < n; i++) exp_ack(1'b1);
        i2c_start();
        quiet = 1'b1;
        oe_count = 0;
        write_byte({addr7, 1'b0});
        for (int i = 0; i < n; i++) write_byte(8'($urandom));
        clk(2);
        quiet = 1'b0;
        check("ignored_sda_oe_cycles", oe_count, 0);
        i2c_stop();
    endtask

    function automatic logic [7:0] pick_ptr();
        logic [7:0] edges[4];
        edges[0] = 8'hFE;
        edges[1] = 8'hFF;
        edges[2] = 8'hF4;
        edges[3] = 8'hF5;
        case ($urandom_range(0, 2))
            0:       return edges[$urandom_range(0, 3)];
            1:       return 8'h10 + 8'($urandom_range(0, 3));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0] p;
        logic [6:0] bad;
        int k;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
        m_ptr = 8'd0;

        clk(5);
        @(negedge clock50);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        clk(10);

        wbuf.delete();
        wbuf.push_back(8'h03);
        txn_write(8'h98, 1'b1);
        txn_read(2, 1'b1, 8'h98);
        txn_read(1, 1'b0, 8'h00);

        txn_wrong(7'h3A, 2);

        wbuf.delete();
        wbuf.push_back(8'hAA);
        wbuf.push_back(8'hBB);
        txn_write(8'hFF, 1'b1);
        txn_read(2, 1'b1, 8'hFF);

        wbuf.delete();
        wbuf.push_back(8'h12);
        txn_write(8'hF5, 1'b1);
        txn_read(1, 1'b1, 8'hF5);

        // Reset while the target is driving a read bit low.
        wbuf.delete();
        wbuf.push_back(8'h5A);
        txn_write(8'h98, 1'b1);
        $display("txn read aborted by reset ptr=98");
        exp_ack(1'b0);
        exp_ack(1'b0);
        exp_ack(1'b0);
        i2c_start();
        write_byte(8'h72);
        write_byte(8'h98);
        i2c_start();
        write_byte(8'h73);
        k = 0;
        while (k < 30 && !sda_oe) begin
            @(negedge clock50);
            k++;
        end
        check("read_bit_driven_low", sda_oe, 1);
        reset = 1'b1;
        @(posedge clock50);
        @(negedge clock50);
        check("reset_releases_sda", sda_oe, 0);
        check("reset_clears_busy", busy, 0);
        for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
        m_ptr = 8'd0;
        clk(3);
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        clk(20);
        txn_read(1, 1'b1, 8'h98);

        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    wbuf.delete();
                    for (int i = 0; i < int'($urandom_range(1, 4)); i++) wbuf.push_back(8'($urandom));
                    txn_write(pick_ptr(), 1'b1);
                end
                1: begin
                    p = pick_ptr();
                    txn_read(int'($urandom_range(1, 4)), 1'b1, p);
                end
                2: txn_read(int'($urandom_range(1, 3)), 1'b0, 8'h00);
                default: begin
                    bad = 7'($urandom);
                    if (bad == 7'h39) bad = 7'h38;
                    txn_wrong(bad, int'($urandom_range(1, 2)));
                end
            endcase
        end

        clk(10);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rx_queue_drained", exp_rx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
